// File: rtl/fifo_wr_packer.sv
// Packs IN_WIDTH lanes into OUT_WIDTH words for the FIFO/LIFO buffer write port.
// Latency: closing lane accepted at edge N -> Wren high from edge N+1 to N+2 when Full is low.
// Backpressure: in_ready drops while a word waits to issue; the buffer's Full holds the word in ISSUE.
//
// Optional feature: define PACKER_STATS_EN to add word_cnt/pad_cnt outputs.
// OUT_WIDTH must be an integer multiple (>= 2) of IN_WIDTH.

module fifo_wr_packer #(
  parameter int                  IN_WIDTH  = 8,
  parameter int                  OUT_WIDTH = 32,
  parameter logic [IN_WIDTH-1:0] PAD       = '0
) (
  input  logic                 Wrclk,
  input  logic                 Rst,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic                 in_ready,
  input  logic                 Full,
  output logic                 Wren,
  output logic [OUT_WIDTH-1:0] Datain,
  output logic                 Wr_padded
`ifdef PACKER_STATS_EN
  ,
  output logic [15:0]          word_cnt,
  output logic [15:0]          pad_cnt
`endif
);

  localparam int RATIO = OUT_WIDTH / IN_WIDTH;
  localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(RATIO - 1);

  typedef enum logic {
    FILL  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [OUT_WIDTH-1:0]   asm_q, asm_d;
  logic                   pad_q, pad_d;
  logic                   wren_q, wren_d;
  logic [OUT_WIDTH-1:0]   datain_q, datain_d;
  logic                   wr_padded_q, wr_padded_d;

  logic                   lane_acc;
  logic                   word_close;
  logic                   word_issue;

  // Ready only while collecting lanes; forced low during reset.
  always_comb begin
    in_ready = (state_q == FILL) && !Rst;
  end

  // Handshake qualifiers shared by the datapath and the statistics.
  always_comb begin
    lane_acc   = in_valid && in_ready;
    word_close = lane_acc && ((cnt_q == LAST_LANE) || in_last);
    word_issue = (state_q == ISSUE) && !Full;
  end

  // Next-state, lane assembly and write-port strobes.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    asm_d       = asm_q;
    pad_d       = pad_q;
    wren_d      = 1'b0;
    datain_d    = datain_q;
    wr_padded_d = 1'b0;

    case (state_q)
      FILL: begin
        if (lane_acc) begin
          // Little-endian: lane cnt lands at bits [cnt*IN_WIDTH +: IN_WIDTH].
          // When this lane closes the word, every higher lane becomes PAD.
          for (int i = 0; i < RATIO; i++) begin
            if (i == int'(cnt_q)) begin
              asm_d[i*IN_WIDTH +: IN_WIDTH] = in_data;
            end else if (word_close && (i > int'(cnt_q))) begin
              asm_d[i*IN_WIDTH +: IN_WIDTH] = PAD;
            end
          end
          if (word_close) begin
            pad_d   = in_last && (cnt_q != LAST_LANE);
            state_d = ISSUE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      ISSUE: begin
        // Full is only consulted here; the word waits as long as the buffer is full.
        if (!Full) begin
          wren_d      = 1'b1;
          datain_d    = asm_q;
          wr_padded_d = pad_q;
          cnt_d       = '0;
          asm_d       = '0;
          pad_d       = 1'b0;
          state_d     = FILL;
        end
      end

      default: begin
        state_d = FILL;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial or pending word.
  always_ff @(posedge Wrclk or posedge Rst) begin
    if (Rst) begin
      state_q     <= FILL;
      cnt_q       <= '0;
      asm_q       <= '0;
      pad_q       <= 1'b0;
      wren_q      <= 1'b0;
      datain_q    <= '0;
      wr_padded_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      asm_q       <= asm_d;
      pad_q       <= pad_d;
      wren_q      <= wren_d;
      datain_q    <= datain_d;
      wr_padded_q <= wr_padded_d;
    end
  end

  // Buffer write port is driven straight from flops.
  always_comb begin
    Wren      = wren_q;
    Datain    = datain_q;
    Wr_padded = wr_padded_q;
  end

`ifdef PACKER_STATS_EN
  logic [15:0] word_cnt_q, word_cnt_d;
  logic [15:0] pad_cnt_q, pad_cnt_d;

  // Saturating counters of issued words and of issued padded words.
  always_comb begin
    word_cnt_d = word_cnt_q;
    pad_cnt_d  = pad_cnt_q;
    if (word_issue && (word_cnt_q != 16'hFFFF)) begin
      word_cnt_d = word_cnt_q + 16'd1;
    end
    if (word_issue && pad_q && (pad_cnt_q != 16'hFFFF)) begin
      pad_cnt_d = pad_cnt_q + 16'd1;
    end
  end

  // Statistics registers, cleared by reset.
  always_ff @(posedge Wrclk or posedge Rst) begin
    if (Rst) begin
      word_cnt_q <= '0;
      pad_cnt_q  <= '0;
    end else begin
      word_cnt_q <= word_cnt_d;
      pad_cnt_q  <= pad_cnt_d;
    end
  end

  // Expose the counters.
  always_comb begin
    word_cnt = word_cnt_q;
    pad_cnt  = pad_cnt_q;
  end
`else
  // Issue qualifier only feeds the statistics block; keep it referenced.
  logic word_issue_unused;
  always_comb begin
    word_issue_unused = word_issue;
  end
`endif

endmodule
